udm_host: RTL and testbench
===========================

Name: udm_host

Overview:
- Host-side initiator for the UDM debug byte protocol. Converts single-word command requests from a local master (test harness CPU, bridge FPGA) into escaped UDM byte frames on a UART transmitter.
- Parses the UDM responder's reply stream from a UART receiver: read data, IDCODE echo, error status bytes.
- Sits between a local command port and a uart_tx/uart_rx pair wired to the target's UDM link.

Parameters:
- RESP_TIMEOUT, 32'd209715200, max idle clock cycles between expected response bytes before the command is aborted with timeout status.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous reset, active-low
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  block can accept a command
- cmd_op_bi  in  3  0=IDCODE, 1=RST, 2=nRST, 3=WRITE, 4=READ, 5=SYNC; 6,7 reserved
- cmd_addr_bi  in  32  word address for WRITE/READ
- cmd_wdata_bi  in  32  write data
- done_o  out  1  one-cycle pulse, command finished
- status_bo  out  2  valid with done_o: 0=OK, 1=ERR_ACK, 2=ERR_RESP, 3=TIMEOUT
- rdata_bo  out  32  read data, valid with done_o for READ/OK
- async_err_o  out  1  pulse: unsolicited 0x01/0x02 byte received while IDLE
- irq_o  out  1  pulse: target IRQ byte received (see Optional Feature)
- tx_dout_bo  out  8  byte to UART tx
- tx_start_o  out  1  one-cycle start pulse to UART tx
- tx_done_tick_i  in  1  UART tx byte complete
- rx_done_tick_i  in  1  UART rx byte valid
- rx_din_bi  in  8  received byte

Behaviour:
- Reset (reset_i==0 at clk edge): state IDLE, cmd_ready_o=1, all other outputs 0, counters cleared. Reset mid-frame abandons the frame; no further tx_start_o is issued. The in-flight UART byte is not recalled.
- Accept: cmd_valid_i & cmd_ready_o; op/addr/wdata are latched and cmd_ready_o drops the next cycle. The first tx_start_o is issued the cycle after acceptance.
- Frames (multi-byte fields LSB first):
  - IDCODE: 0x00
  - RST: 0x80
  - nRST: 0xC0
  - SYNC: 0x55
  - WRITE: 0x83, addr[4], 04 00 00 00, wdata[4]
  - READ: 0x84, addr[4], 04 00 00 00
- Tx escaping: command and SYNC bytes are sent raw. Any addr/length/wdata byte equal to 0x55 or 0x5A is sent as 0x5A followed by the byte.
- Tx handshake: one tx_start_o per byte. The next byte is not started until tx_done_tick_i. tx_dout_bo is held stable from start until done.
- FSM states: IDLE, TX_BYTE, TX_WAIT, RX_IDCODE, RX_DATA, DONE.
  - TX_BYTE issues start, then moves to TX_WAIT.
  - TX_WAIT, on done: next byte goes to TX_BYTE; end of frame goes to RX_IDCODE (IDCODE), RX_DATA (READ), or DONE (RST/nRST/SYNC/WRITE with status OK).
  - DONE pulses done_o one cycle, then returns to IDLE with cmd_ready_o=1.
- Rx decoder: runs in all states and keeps escape_pending.
  - escape_pending=1: the byte is literal data; clear the flag.
  - Otherwise, 0x5A sets escape_pending.
  - Otherwise, 0x00 is IRQ, 0x01 is ERR_ACK, 0x02 is ERR_RESP.
  - Otherwise the byte is data, including 0x55.
- RX_IDCODE: data byte 0x55 gives DONE/OK. Any other data byte is ignored.
- RX_DATA: 4 data bytes are shifted in LSB first, rdata_bo = {b3,b2,b1,b0}, then DONE/OK.
- ERR_ACK or ERR_RESP in RX_IDCODE/RX_DATA: DONE with status 1 or 2, rdata_bo=0.
- Same bytes in IDLE: async_err_o pulse. Same bytes in TX states: ignored.
- Timeout: 32-bit counter, cleared on entry to RX_* and on every rx_done_tick_i. When counter > RESP_TIMEOUT: DONE with status 3 and escape_pending cleared.
- Simultaneous rx_done_tick_i and timeout: the received byte wins.
- IRQ byte never alters the FSM.
- Reserved op: no bytes sent; DONE with status OK next cycle.

Optional Feature:
- Macro UDM_HOST_IRQ_EN.
- Defined: unescaped 0x00 gives irq_o one-cycle pulse in any state.
- Undefined: irq_o tied 0; unescaped 0x00 silently discarded.

Test Plan:
- WRITE addr=0x00001055, wdata=0x5A0000FF -> tx bytes 83 5A 55 10 00 00 04 00 00 00 FF 00 00 5A 5A. done_o with status 0 after last tx_done_tick_i.
- READ addr=0x10 with responder replying 5A 01, 55, 5A 5A, 7F -> rdata_bo=0x7F5A5501, status 0.
- IDCODE with reply 55 -> status 0. Repeat with no reply and RESP_TIMEOUT=100 -> status 3 at 101+ idle cycles.
- READ with reply byte 02 after the frame -> status 2, rdata_bo=0. Then byte 01 while IDLE -> async_err_o pulse, no done_o.
- reset_i low during byte 5 of a WRITE -> tx_start_o stops and all outputs are 0. Next IDCODE completes normally.
- With UDM_HOST_IRQ_EN: byte 00 during RX_DATA -> irq_o pulse and the read still completes. Without the macro: irq_o stays 0.

Source files
------------

// File: rtl/udm_host.sv
// udm_host: UDM debug-protocol host. Frames local commands into escaped UART bytes and decodes the responder's reply stream.
// Optional IRQ reporting: define UDM_HOST_IRQ_EN to pulse irq_o on unescaped 0x00 bytes.
module udm_host #(
    parameter logic [31:0] RESP_TIMEOUT = 32'd209715200
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [2:0]  cmd_op_bi,
    input  logic [31:0] cmd_addr_bi,
    input  logic [31:0] cmd_wdata_bi,
    output logic        done_o,
    output logic [1:0]  status_bo,
    output logic [31:0] rdata_bo,
    output logic        async_err_o,
    output logic        irq_o,
    output logic [7:0]  tx_dout_bo,
    output logic        tx_start_o,
    input  logic        tx_done_tick_i,
    input  logic        rx_done_tick_i,
    input  logic [7:0]  rx_din_bi
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TX_BYTE   = 3'd1,
        S_TX_WAIT   = 3'd2,
        S_RX_IDCODE = 3'd3,
        S_RX_DATA   = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam logic [2:0] OP_IDCODE = 3'd0;
    localparam logic [2:0] OP_RST    = 3'd1;
    localparam logic [2:0] OP_NRST   = 3'd2;
    localparam logic [2:0] OP_WRITE  = 3'd3;
    localparam logic [2:0] OP_READ   = 3'd4;
    localparam logic [2:0] OP_SYNC   = 3'd5;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_ERR_ACK  = 2'd1;
    localparam logic [1:0] ST_ERR_RESP = 2'd2;
    localparam logic [1:0] ST_TIMEOUT  = 2'd3;

    // Unescaped byte idx of the frame for op; length field is always one word.
    function automatic logic [7:0] frame_byte(input logic [2:0] op, input logic [31:0] addr,
                                              input logic [31:0] wdata, input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0: begin
                case (op)
                    OP_IDCODE: b = 8'h00;
                    OP_RST:    b = 8'h80;
                    OP_NRST:   b = 8'hC0;
                    OP_WRITE:  b = 8'h83;
                    OP_READ:   b = 8'h84;
                    OP_SYNC:   b = 8'h55;
                    default:   b = 8'h00;
                endcase
            end
            4'd1:    b = addr[7:0];
            4'd2:    b = addr[15:8];
            4'd3:    b = addr[23:16];
            4'd4:    b = addr[31:24];
            4'd5:    b = 8'h04;
            4'd9:    b = wdata[7:0];
            4'd10:   b = wdata[15:8];
            4'd11:   b = wdata[23:16];
            4'd12:   b = wdata[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [3:0] frame_len(input logic [2:0] op);
        logic [3:0] n;
        case (op)
            OP_IDCODE, OP_RST, OP_NRST, OP_SYNC: n = 4'd1;
            OP_WRITE: n = 4'd13;
            OP_READ:  n = 4'd9;
            default:  n = 4'd0;
        endcase
        return n;
    endfunction

    function automatic logic needs_esc(input logic [3:0] idx, input logic [7:0] b);
        return (idx != 4'd0) && ((b == 8'h55) || (b == 8'h5A));
    endfunction

    state_t       state_r, state_s;
    logic [2:0]   op_r;
    logic [31:0]  addr_r, wdata_r;
    logic [3:0]   idx_r, idx_s;
    logic         esc_ph_r, esc_ph_s;
    logic         rx_esc_r, rx_esc_s;
    logic [31:0]  cnt_r;
    logic [1:0]   rx_cnt_r;
    logic [31:0]  rx_sh_r;
    logic         cmd_ready_r, done_r, async_err_r, irq_r, tx_start_r;
    logic [1:0]   status_r, status_s;
    logic [31:0]  rdata_r, rdata_s;
    logic [7:0]   tx_dout_r;
    logic         accept_s, timeout_s, rx_lit_s, rx_eack_s, rx_eresp_s;
    logic         in_rx_r_s, in_rx_s_s;
    logic [7:0]   cur_raw_s, nxt_raw_s, nxt_byte_s;
    logic [2:0]   f_op_s;
    logic [31:0]  f_addr_s, f_wdata_s;

    assign accept_s  = cmd_valid_i && cmd_ready_r;
    assign in_rx_r_s = (state_r == S_RX_IDCODE) || (state_r == S_RX_DATA);
    assign in_rx_s_s = (state_s == S_RX_IDCODE) || (state_s == S_RX_DATA);

    // Rx byte classifier with escape tracking
    always_comb begin
        rx_lit_s   = 1'b0;
        rx_eack_s  = 1'b0;
        rx_eresp_s = 1'b0;
        rx_esc_s   = rx_esc_r;
        if (rx_done_tick_i) begin
            if (rx_esc_r) begin
                rx_lit_s = 1'b1;
                rx_esc_s = 1'b0;
            end else begin
                case (rx_din_bi)
                    8'h5A:   rx_esc_s   = 1'b1;
                    8'h00:   rx_lit_s   = 1'b0;
                    8'h01:   rx_eack_s  = 1'b1;
                    8'h02:   rx_eresp_s = 1'b1;
                    default: rx_lit_s   = 1'b1;
                endcase
            end
        end else begin
            rx_lit_s = 1'b0;
        end
    end

    // Next-state and completion status
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        esc_ph_s  = esc_ph_r;
        status_s  = ST_OK;
        rdata_s   = 32'h0;
        timeout_s = 1'b0;
        cur_raw_s = frame_byte(op_r, addr_r, wdata_r, idx_r);
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    idx_s    = 4'd0;
                    esc_ph_s = 1'b0;
                    if (frame_len(cmd_op_bi) == 4'd0) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_TX_BYTE;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_TX_BYTE: state_s = S_TX_WAIT;
            S_TX_WAIT: begin
                if (!tx_done_tick_i) begin
                    state_s = S_TX_WAIT;
                end else if (needs_esc(idx_r, cur_raw_s) && !esc_ph_r) begin
                    esc_ph_s = 1'b1;
                    state_s  = S_TX_BYTE;
                end else if ((idx_r + 4'd1) == frame_len(op_r)) begin
                    if (op_r == OP_IDCODE) begin
                        state_s = S_RX_IDCODE;
                    end else if (op_r == OP_READ) begin
                        state_s = S_RX_DATA;
                    end else begin
                        state_s = S_DONE;
                    end
                end else begin
                    idx_s    = idx_r + 4'd1;
                    esc_ph_s = 1'b0;
                    state_s  = S_TX_BYTE;
                end
            end
            S_RX_IDCODE, S_RX_DATA: begin
                if (rx_eack_s) begin
                    state_s  = S_DONE;
                    status_s = ST_ERR_ACK;
                end else if (rx_eresp_s) begin
                    state_s  = S_DONE;
                    status_s = ST_ERR_RESP;
                end else if (rx_lit_s && (state_r == S_RX_IDCODE) && (rx_din_bi == 8'h55)) begin
                    state_s = S_DONE;
                end else if (rx_lit_s && (state_r == S_RX_DATA) && (rx_cnt_r == 2'd3)) begin
                    state_s = S_DONE;
                    rdata_s = {rx_din_bi, rx_sh_r[31:8]};
                end else if (!rx_done_tick_i && (cnt_r > RESP_TIMEOUT)) begin
                    state_s   = S_DONE;
                    status_s  = ST_TIMEOUT;
                    timeout_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Byte to present on the UART for the upcoming TX_BYTE cycle
    always_comb begin
        if (state_r == S_IDLE) begin
            f_op_s    = cmd_op_bi;
            f_addr_s  = cmd_addr_bi;
            f_wdata_s = cmd_wdata_bi;
        end else begin
            f_op_s    = op_r;
            f_addr_s  = addr_r;
            f_wdata_s = wdata_r;
        end
        nxt_raw_s = frame_byte(f_op_s, f_addr_s, f_wdata_s, idx_s);
        if (needs_esc(idx_s, nxt_raw_s) && !esc_ph_s) begin
            nxt_byte_s = 8'h5A;
        end else begin
            nxt_byte_s = nxt_raw_s;
        end
    end

    // FSM, frame pointer and latched command
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_r  <= S_IDLE;
            idx_r    <= 4'd0;
            esc_ph_r <= 1'b0;
            op_r     <= 3'd0;
            addr_r   <= 32'h0;
            wdata_r  <= 32'h0;
        end else begin
            state_r  <= state_s;
            idx_r    <= idx_s;
            esc_ph_r <= esc_ph_s;
            if (accept_s) begin
                op_r    <= cmd_op_bi;
                addr_r  <= cmd_addr_bi;
                wdata_r <= cmd_wdata_bi;
            end
        end
    end

    // Rx escape flag, response timer and read-data shifter
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            rx_esc_r <= 1'b0;
            cnt_r    <= 32'h0;
            rx_cnt_r <= 2'd0;
            rx_sh_r  <= 32'h0;
        end else begin
            rx_esc_r <= timeout_s ? 1'b0 : rx_esc_s;
            if (rx_done_tick_i || (in_rx_s_s && !in_rx_r_s) || !in_rx_r_s) begin
                cnt_r <= 32'h0;
            end else if (cnt_r != 32'hFFFF_FFFF) begin
                cnt_r <= cnt_r + 32'd1;
            end
            if (state_r != S_RX_DATA) begin
                rx_cnt_r <= 2'd0;
                rx_sh_r  <= 32'h0;
            end else if (rx_lit_s) begin
                rx_cnt_r <= rx_cnt_r + 2'd1;
                rx_sh_r  <= {rx_din_bi, rx_sh_r[31:8]};
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cmd_ready_r <= 1'b1;
            done_r      <= 1'b0;
            status_r    <= 2'd0;
            rdata_r     <= 32'h0;
            async_err_r <= 1'b0;
            irq_r       <= 1'b0;
            tx_start_r  <= 1'b0;
            tx_dout_r   <= 8'h00;
        end else begin
            cmd_ready_r <= (state_s == S_IDLE);
            done_r      <= (state_s == S_DONE);
            tx_start_r  <= (state_s == S_TX_BYTE);
            async_err_r <= (state_r == S_IDLE) && (rx_eack_s || rx_eresp_s);
`ifdef UDM_HOST_IRQ_EN
            irq_r       <= rx_done_tick_i && !rx_esc_r && (rx_din_bi == 8'h00);
`else
            irq_r       <= 1'b0;
`endif
            if (state_s == S_DONE) begin
                status_r <= status_s;
                rdata_r  <= rdata_s;
            end
            if (state_s == S_TX_BYTE) begin
                tx_dout_r <= nxt_byte_s;
            end
        end
    end

    assign cmd_ready_o = cmd_ready_r;
    assign done_o      = done_r;
    assign status_bo   = status_r;
    assign rdata_bo    = rdata_r;
    assign async_err_o = async_err_r;
    assign irq_o       = irq_r;
    assign tx_start_o  = tx_start_r;
    assign tx_dout_bo  = tx_dout_r;
endmodule

// File: tb/tb_udm_host.sv
// Scoreboard bench for udm_host: expected tx bytes and completions are queued at stimulus time and checked by a monitor.
module tb_udm_host;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [2:0]  cmd_op_bi;
    logic [31:0] cmd_addr_bi, cmd_wdata_bi;
    logic        done_o;
    logic [1:0]  status_bo;
    logic [31:0] rdata_bo;
    logic        async_err_o, irq_o;
    logic [7:0]  tx_dout_bo;
    logic        tx_start_o, tx_done_tick_i, rx_done_tick_i;
    logic [7:0]  rx_din_bi;

`ifdef UDM_HOST_IRQ_EN
    localparam int IRQ_EXP = 1;
`else
    localparam int IRQ_EXP = 0;
`endif

    typedef struct packed {
        logic [1:0]  st;
        logic [31:0] rd;
        logic        chk;
    } done_exp_t;

    logic [7:0] exp_tx[$];
    done_exp_t  exp_done[$];
    logic [7:0] bq[$];
    int checks = 0, failures = 0;
    int done_cnt = 0, start_cnt = 0, async_cnt = 0, irq_cnt = 0;

    udm_host #(.RESP_TIMEOUT(32'd100)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_bi(cmd_op_bi), .cmd_addr_bi(cmd_addr_bi), .cmd_wdata_bi(cmd_wdata_bi),
        .done_o(done_o), .status_bo(status_bo), .rdata_bo(rdata_bo),
        .async_err_o(async_err_o), .irq_o(irq_o),
        .tx_dout_bo(tx_dout_bo), .tx_start_o(tx_start_o), .tx_done_tick_i(tx_done_tick_i),
        .rx_done_tick_i(rx_done_tick_i), .rx_din_bi(rx_din_bi)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Monitor: compares tx bytes and completions against the scoreboard
    always @(negedge clk_i) begin
        if (reset_i) begin
            if (tx_start_o) begin
                start_cnt++;
                if (exp_tx.size() == 0) check_eq("tx_extra", exp_tx.size(), 1);
                else check_eq("tx_byte", tx_dout_bo, exp_tx.pop_front());
            end
            if (done_o) begin
                done_exp_t e;
                done_cnt++;
                if (exp_done.size() == 0) begin
                    check_eq("done_extra", exp_done.size(), 1);
                end else begin
                    e = exp_done.pop_front();
                    check_eq("status", status_bo, e.st);
                    if (e.chk) check_eq("rdata", rdata_bo, e.rd);
                end
            end
            if (async_err_o) async_cnt++;
            if (irq_o) irq_cnt++;
        end
    end

    task automatic push_tx(input logic [7:0] bs[$]);
        foreach (bs[i]) exp_tx.push_back(bs[i]);
    endtask

    task automatic push_done(input logic [1:0] st, input logic [31:0] rd, input logic chk);
        done_exp_t e;
        e.st = st; e.rd = rd; e.chk = chk;
        exp_done.push_back(e);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w);
        int k = 0;
        while (!cmd_ready_o && k < 50) begin @(posedge clk_i); #1; k++; end
        check_eq("ready_before_issue", cmd_ready_o, 1);
        cmd_op_bi = op; cmd_addr_bi = a; cmd_wdata_bi = w; cmd_valid_i = 1'b1;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        check_eq("ready_drop", cmd_ready_o, 0);
    endtask

    task automatic wait_start();
        int k = 0;
        while (!tx_start_o && k < 50) begin @(posedge clk_i); #1; k++; end
        check_eq("tx_start_seen", tx_start_o, 1);
    endtask

    task automatic serve_frame(input int n, input int d0);
        for (int i = 0; i < n; i++) begin
            wait_start();
            repeat (3) @(posedge clk_i);
            #1;
            if (i == n - 1) check_eq("early_done", done_cnt, d0);
            tx_done_tick_i = 1'b1;
            @(posedge clk_i); #1;
            tx_done_tick_i = 1'b0;
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_din_bi = b; rx_done_tick_i = 1'b1;
        @(posedge clk_i); #1;
        rx_done_tick_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic send_rx_q(input logic [7:0] bs[$]);
        foreach (bs[i]) send_rx(bs[i]);
    endtask

    task automatic wait_done(input int d0, input int budget);
        int k = 0;
        while (done_cnt <= d0 && k < budget) begin @(posedge clk_i); #1; k++; end
        check_eq("done_count", done_cnt, d0 + 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, s0, a0, i0, n;
        reset_i = 1'b0; cmd_valid_i = 1'b0; cmd_op_bi = 3'd0; cmd_addr_bi = 32'h0; cmd_wdata_bi = 32'h0;
        tx_done_tick_i = 1'b0; rx_done_tick_i = 1'b0; rx_din_bi = 8'h00;
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_ready", cmd_ready_o, 1);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_status", status_bo, 0);
        check_eq("rst_rdata", rdata_bo, 0);
        check_eq("rst_tx_start", tx_start_o, 0);
        check_eq("rst_tx_dout", tx_dout_bo, 0);
        check_eq("rst_async", async_err_o, 0);
        check_eq("rst_irq", irq_o, 0);
        reset_i = 1'b1;
        @(posedge clk_i); #1;

        // WRITE with escaped address and data bytes
        bq = '{8'h83, 8'h5A, 8'h55, 8'h10, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00,
               8'hFF, 8'h00, 8'h00, 8'h5A, 8'h5A};
        push_tx(bq); push_done(2'd0, 32'h0, 1'b0);
        d0 = done_cnt;
        issue(3'd3, 32'h0000_1055, 32'h5A00_00FF);
        serve_frame(15, d0);
        wait_done(d0, 20);

        // READ with escaped reply bytes
        bq = '{8'h84, 8'h10, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
        push_tx(bq); push_done(2'd0, 32'h7F5A_5501, 1'b1);
        d0 = done_cnt;
        issue(3'd4, 32'h0000_0010, 32'h0);
        serve_frame(9, d0);
        bq = '{8'h5A, 8'h01, 8'h55, 8'h5A, 8'h5A, 8'h7F};
        send_rx_q(bq);
        wait_done(d0, 20);

        // IDCODE answered
        bq = '{8'h00}; push_tx(bq); push_done(2'd0, 32'h0, 1'b0);
        d0 = done_cnt;
        issue(3'd0, 32'h0, 32'h0);
        serve_frame(1, d0);
        send_rx(8'h55);
        wait_done(d0, 20);

        // IDCODE unanswered: timeout
        bq = '{8'h00}; push_tx(bq); push_done(2'd3, 32'h0, 1'b0);
        d0 = done_cnt;
        issue(3'd0, 32'h0, 32'h0);
        serve_frame(1, d0);
        n = 0;
        while (!done_o && n < 300) begin @(posedge clk_i); #1; n++; end
        check_eq("timeout_latency", ((n >= 101) && (n <= 110)) ? 32'd1 : 32'd0, 32'd1);
        wait_done(d0, 5);

        // READ answered with ERR_RESP, then an unsolicited ERR_ACK while idle
        bq = '{8'h84, 8'h20, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
        push_tx(bq); push_done(2'd2, 32'h0, 1'b1);
        d0 = done_cnt;
        issue(3'd4, 32'h0000_0020, 32'h0);
        serve_frame(9, d0);
        send_rx(8'h02);
        wait_done(d0, 20);
        a0 = async_cnt; d0 = done_cnt;
        send_rx(8'h01);
        repeat (5) @(posedge clk_i);
        #1;
        check_eq("async_err_pulse", async_cnt, a0 + 1);
        check_eq("async_no_done", done_cnt, d0);

        // Reset during byte 5 of a WRITE
        bq = '{8'h83, 8'h78, 8'h56, 8'h34, 8'h12, 8'h04, 8'h00, 8'h00, 8'h00,
               8'hF0, 8'hDE, 8'hBC, 8'h9A};
        push_tx(bq);
        d0 = done_cnt;
        issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        serve_frame(4, d0);
        wait_start();
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        check_eq("mid_rst_tx_start", tx_start_o, 0);
        check_eq("mid_rst_tx_dout", tx_dout_bo, 0);
        check_eq("mid_rst_ready", cmd_ready_o, 1);
        check_eq("mid_rst_done", done_o, 0);
        check_eq("mid_rst_rdata", rdata_bo, 0);
        reset_i = 1'b1;
        exp_tx.delete();
        s0 = start_cnt;
        repeat (20) @(posedge clk_i);
        #1;
        check_eq("no_start_after_rst", start_cnt, s0);
        check_eq("no_done_after_rst", done_cnt, d0);
        bq = '{8'h00}; push_tx(bq); push_done(2'd0, 32'h0, 1'b0);
        issue(3'd0, 32'h0, 32'h0);
        serve_frame(1, d0);
        send_rx(8'h55);
        wait_done(d0, 20);

        // Reserved op: completes with no bytes sent
        push_done(2'd0, 32'h0, 1'b0);
        d0 = done_cnt; s0 = start_cnt;
        issue(3'd7, 32'h0, 32'h0);
        wait_done(d0, 5);
        check_eq("reserved_no_tx", start_cnt, s0);

        // SYNC is sent raw
        bq = '{8'h55}; push_tx(bq); push_done(2'd0, 32'h0, 1'b0);
        d0 = done_cnt;
        issue(3'd5, 32'h0, 32'h0);
        serve_frame(1, d0);
        wait_done(d0, 20);

        // IRQ byte inside a read reply
        bq = '{8'h84, 8'h30, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
        push_tx(bq); push_done(2'd0, 32'h4433_2211, 1'b1);
        d0 = done_cnt; i0 = irq_cnt;
        issue(3'd4, 32'h0000_0030, 32'h0);
        serve_frame(9, d0);
        bq = '{8'h11, 8'h00, 8'h22, 8'h33, 8'h44};
        send_rx_q(bq);
        wait_done(d0, 20);
        check_eq("irq_count", irq_cnt, i0 + IRQ_EXP);

        repeat (3) @(posedge clk_i);
        #1;
        check_eq("tx_queue_drained", exp_tx.size(), 0);
        check_eq("done_queue_drained", exp_done.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
